operand_packer: RTL and testbench
=================================

OPERAND_PACKER -- requirements
Module: operand_packer

Interface
REQ-001 SHALL have parameter N_OPS, default 12, operands per packed word (fixed; matches the 12-operand tree adder input).
REQ-002 SHALL have parameter OP_W, default 3, bits per operand.
REQ-003 SHALL have one clock; reset is asynchronous and active-low (ports clk, reset_n).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  producer presents in_data this cycle.
REQ-007 in_ready  output  1  packer accepts in_data this cycle.
REQ-008 in_data  input  3  one operand.
REQ-009 in_last  input  1  qualifies in_data as final operand of a short group.
REQ-010 out_valid  output  1  out_op holds a complete packed word.
REQ-011 out_ready  input  1  consumer takes out_op this cycle.
REQ-012 out_op  output  36  packed operands, slot k at bits [3k+2:3k].
REQ-013 out_count  output  4  number of real operands in out_op (1..12).

Function
REQ-014 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer on a cycle with out_valid && out_ready.
REQ-015 The first operand accepted after a word boundary SHALL go to slot 0; each further accept fills the next slot.
REQ-016 A fill counter (0..11) SHALL count accepted operands of the current group.
REQ-017 A group SHALL complete on the accept that fills slot 11, or on any accept with in_last=1, whichever comes first.
REQ-018 On short completion, unfilled slots SHALL be zero; out_count SHALL equal counter+1 at the completing accept.
REQ-019 in_last on the 12th accept SHALL give out_count=12, identical to a full group.
REQ-020 The block SHALL have two states: FILL (in_ready=1) and HOLD (in_ready=0, completed group parked in the fill buffer).
REQ-021 On completion in FILL, if the output register is free this cycle (out_valid=0, or out_ready=1), the group SHALL load into out_op/out_count, out_valid=1 next cycle, counter=0, state stays FILL.
REQ-022 On completion in FILL with the output register occupied and out_ready=0, the group SHALL park in the fill buffer and state SHALL go to HOLD.
REQ-023 In HOLD, on the first cycle the output register is free, the parked group SHALL move to out_op/out_count, counter=0, state returns to FILL (in_ready=1 next cycle).
REQ-024 Latency from completing accept to out_valid SHALL be 1 cycle when not stalled; sustained throughput SHALL be one word per 12 accepts with no bubble.
REQ-025 While out_valid=1 and out_ready=0, out_op and out_count SHALL remain unchanged.
REQ-026 out_valid SHALL clear after an output transfer unless a new group loads the same cycle.
REQ-027 in_last with in_valid=0 SHALL be ignored; in_data SHALL be ignored when not accepted.
REQ-028 Counter SHALL never exceed 11; no operand SHALL be dropped or duplicated.

Reset
REQ-029 While reset_n=0: out_valid=0, out_op=0, out_count=0, counter=0, fill buffer=0, state=FILL.
REQ-030 in_ready SHALL be 1 on the first cycle after reset release.
REQ-031 Reset asserted mid-group or in HOLD SHALL discard partial and parked groups; no word SHALL be emitted for them after release.

Verification
REQ-032 12 accepts of in_data=7, out_ready=1 -> out_valid one cycle after 12th accept, out_op=36'hFFFFFFFFF, out_count=12.
REQ-033 Accept 1,2,3 with in_last on 3 -> out_op=36'h0000000D1, out_count=3.
REQ-034 Two full groups back-to-back (0..5 repeated twice; then 7 x12), out_ready=0 -> first word held stable, in_ready=0 after second completes (HOLD); raising out_ready drains word 1, then word 2 next cycle, in_ready returns to 1.
REQ-035 Continuous in_valid=1, out_ready=1, 36 accepts -> exactly 3 words, out_valid pulses every 12 cycles, in_ready never drops.
REQ-036 reset_n pulsed low after 5 accepts, then 12 accepts of 1 -> single word out_op=36'h249249249, out_count=12.
REQ-037 Random in_valid/out_ready stress with scoreboard -> every accepted operand appears once, in order, with correct out_count.

Source files
------------

// File: rtl/operand_packer.sv
// Gathers a stream of small operands into one packed word for the tree adder.
// in_last closes a short group; one completed group can wait while the output register is full.
module operand_packer #(
    parameter int N_OPS = 12,
    parameter int OP_W  = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_W-1:0]              in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_OPS*OP_W-1:0]        out_op,
    output logic [$clog2(N_OPS+1)-1:0]   out_count
);
    localparam int W     = N_OPS * OP_W;
    localparam int CNT_W = $clog2(N_OPS + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   park_cnt_q, park_cnt_d;
    logic [W-1:0]       buf_q, buf_d;
    logic [W-1:0]       out_op_q, out_op_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_vld_q, out_vld_d;

    logic               accept, complete, out_free;
    logic [W-1:0]       buf_wr;

    assign in_ready  = (state_q == FILL);
    assign out_valid = out_vld_q;
    assign out_op    = out_op_q;
    assign out_count = out_cnt_q;

    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || cnt_q == CNT_W'(N_OPS - 1));
    assign out_free = !out_vld_q || out_ready;

    always_comb begin
        buf_wr = buf_q;
        buf_wr[cnt_q*OP_W +: OP_W] = in_data;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        park_cnt_d = park_cnt_q;
        buf_d      = buf_q;
        out_op_d   = out_op_q;
        out_cnt_d  = out_cnt_q;
        // A transfer empties the output register unless something reloads it below.
        out_vld_d  = out_vld_q && !out_ready;

        unique case (state_q)
            FILL: begin
                if (complete) begin
                    if (out_free) begin
                        out_op_d  = buf_wr;
                        out_cnt_d = cnt_q + 1'b1;
                        out_vld_d = 1'b1;
                        buf_d     = '0;
                        cnt_d     = '0;
                    end else begin
                        buf_d      = buf_wr;
                        park_cnt_d = cnt_q + 1'b1;
                        state_d    = HOLD;
                    end
                end else if (accept) begin
                    buf_d = buf_wr;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_free) begin
                    out_op_d  = buf_q;
                    out_cnt_d = park_cnt_q;
                    out_vld_d = 1'b1;
                    buf_d     = '0;
                    cnt_d     = '0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            park_cnt_q <= '0;
            buf_q      <= '0;
            out_op_q   <= '0;
            out_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            park_cnt_q <= park_cnt_d;
            buf_q      <= buf_d;
            out_op_q   <= out_op_d;
            out_cnt_q  <= out_cnt_d;
            out_vld_q  <= out_vld_d;
        end
    end
endmodule

// File: tb/tb_operand_packer.sv
// Scoreboard bench for operand_packer: directed scenarios plus a random handshake stress.
module tb_operand_packer;
    localparam int N  = 12;
    localparam int OW = 3;
    localparam int W  = N * OW;

    logic          clk = 0;
    logic          reset_n = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [OW-1:0] in_data = 0;
    logic          in_last = 0;
    logic          out_valid;
    logic          out_ready = 0;
    logic [W-1:0]  out_op;
    logic [3:0]    out_count;

    operand_packer #(.N_OPS(N), .OP_W(OW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_count(out_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a list of accepted operands forming the open group, and
    // a queue of words that must come out, in order.
    int           cur[$];
    logic [W-1:0] exp_op[$];
    int           exp_cnt[$];
    int           words_seen = 0;
    int           cyc = 0;
    bit           spacing_en = 0;
    int           last_cyc = -1;
    bit           prev_stall = 0;
    logic [W-1:0] prev_op;
    logic [3:0]   prev_cnt;

    function automatic logic [W-1:0] pack(input int ops[$]);
        logic [W-1:0] w = '0;
        for (int i = 0; i < ops.size(); i++)
            w = w | (W'(ops[i]) << (i * OW));
        return w;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            cur.delete();
            exp_op.delete();
            exp_cnt.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_op", out_op, prev_op);
                check("stall_cnt", out_count, prev_cnt);
            end
            if (spacing_en) check("no_in_ready_drop", in_ready, 1);
            if (out_valid && out_ready) begin
                words_seen++;
                if (exp_op.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    check("word_op", out_op, exp_op.pop_front());
                    check("word_cnt", out_count, exp_cnt.pop_front());
                end
                if (spacing_en) begin
                    if (last_cyc >= 0) check("word_spacing", cyc - last_cyc, 12);
                    last_cyc = cyc;
                end
            end
            if (in_valid && in_ready) begin
                cur.push_back(int'(in_data));
                if (cur.size() == N || in_last) begin
                    exp_op.push_back(pack(cur));
                    exp_cnt.push_back(cur.size());
                    cur.delete();
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_op    = out_op;
            prev_cnt   = out_count;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [OW-1:0] d, input logic last);
        int guard = 0;
        in_valid = 1; in_data = d; in_last = last;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0; in_last = 0; in_data = $urandom;
    endtask

    initial begin
        logic [W-1:0] w1;
        int base;
        int tmp[$];

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_op", out_op, 0);
        check("rst_out_count", out_count, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset_n = 1;
        tick(1);
        check("post_rst_in_ready", in_ready, 1);

        // Twelve sevens, unstalled: word visible one cycle after the last accept
        out_ready = 1;
        for (int i = 0; i < N; i++) send(3'd7, 0);
        check("full_valid_latency", out_valid, 1);
        check("full_op", out_op, 36'hFFFFFFFFF);
        check("full_cnt", out_count, 12);
        tick(2);

        // Short group 1,2,3
        send(3'd1, 0); send(3'd2, 0); send(3'd3, 1);
        check("short_valid", out_valid, 1);
        check("short_op", out_op, 36'h0000000D1);
        check("short_cnt", out_count, 3);
        tick(1);
        check("short_clear", out_valid, 0);

        // in_last without in_valid is ignored
        in_last = 1; tick(2); in_last = 0;
        check("idle_last_ignored", out_valid, 0);

        // Back-to-back groups with the consumer stalled
        out_ready = 0;
        tmp.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 6; i++) begin
                send(OW'(i), 0);
                tmp.push_back(i);
            end
        w1 = pack(tmp);
        for (int i = 0; i < N; i++) send(3'd7, 0);
        check("hold_in_ready", in_ready, 0);
        check("hold_out_valid", out_valid, 1);
        check("hold_out_op", out_op, w1);
        tick(3);
        check("hold_still", in_ready, 0);
        out_ready = 1;
        tick(1);
        check("drain2_op", out_op, 36'hFFFFFFFFF);
        check("drain2_valid", out_valid, 1);
        check("hold_exit_in_ready", in_ready, 1);
        tick(1);
        check("drain_done", out_valid, 0);
        tick(2);

        // Continuous stream of 36 accepts
        base = words_seen;
        last_cyc = -1;
        spacing_en = 1;
        for (int i = 0; i < 3 * N; i++) send(OW'($urandom), 0);
        tick(1);
        spacing_en = 0;
        tick(1);
        check("stream_words", words_seen - base, 3);

        // Reset mid-group discards the partial group
        base = words_seen;
        for (int i = 0; i < 5; i++) send(3'd6, 0);
        reset_n = 0;
        tick(2);
        check("midrst_valid", out_valid, 0);
        reset_n = 1;
        tick(1);
        check("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < N; i++) send(3'd1, 0);
        check("midrst_op", out_op, 36'h249249249);
        check("midrst_cnt", out_count, 12);
        tick(3);
        check("midrst_words", words_seen - base, 1);

        // Reset while parked in HOLD
        out_ready = 0;
        for (int i = 0; i < 2 * N; i++) send(3'd5, 0);
        check("hold2_in_ready", in_ready, 0);
        reset_n = 0;
        tick(1);
        reset_n = 1;
        out_ready = 1;
        tick(3);
        check("hold_rst_no_word", out_valid, 0);

        // Random handshake stress
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = OW'($urandom);
            in_last   = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        in_valid = 0; in_last = 0; out_ready = 1;
        for (int g = 0; g < 50 && exp_op.size() != 0; g++) tick(1);
        check("stress_drained", exp_op.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
